// File: rtl/operand_bank.sv
// operand_bank: gathers NUM_OPS operands of WIDTH bits into a flat bus and holds the set until acknowledged.
// Optional feature macro OPERAND_BANK_BACKSPACE_EN adds a delete-last-operand strobe (del).
module operand_bank #(
  parameter int WIDTH   = 8,
  parameter int NUM_OPS = 2,
  localparam int IDXW   = (NUM_OPS > 2) ? $clog2(NUM_OPS) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     data_valid,
  input  logic                     clear,
  input  logic                     ops_ack,
`ifdef OPERAND_BANK_BACKSPACE_EN
  input  logic                     del,
`endif
  output logic [NUM_OPS*WIDTH-1:0] operands,
  output logic [IDXW-1:0]          op_index,
  output logic                     ops_ready
);

  localparam logic [0:0]               COLLECT  = 1'b0;
  localparam logic [0:0]               FULL     = 1'b1;
  localparam logic [IDXW-1:0]          IDX_ZERO = {IDXW{1'b0}};
  localparam logic [IDXW-1:0]          IDX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0]          LAST_IDX = IDXW'(NUM_OPS - 1);
  localparam logic [NUM_OPS*WIDTH-1:0] OPS_ZERO = {(NUM_OPS*WIDTH){1'b0}};

  logic [0:0]               state_q, state_d;
  logic [IDXW-1:0]          op_index_q, op_index_d;
  logic [NUM_OPS*WIDTH-1:0] operands_q, operands_d;
  logic                     ops_ready_q, ops_ready_d;

`ifdef OPERAND_BANK_BACKSPACE_EN
  logic [IDXW-1:0]          prev_idx_s;
  assign prev_idx_s = op_index_q - IDX_ONE;
`endif

  // Next-state logic: clear beats ack, ack beats del, del beats data_valid.
  always_comb begin
    state_d    = state_q;
    op_index_d = op_index_q;
    operands_d = operands_q;
    if (clear) begin
      state_d    = COLLECT;
      op_index_d = IDX_ZERO;
      operands_d = OPS_ZERO;
    end else begin
      case (state_q)
        COLLECT: begin
`ifdef OPERAND_BANK_BACKSPACE_EN
          if (del && (op_index_q != IDX_ZERO)) begin
            op_index_d = prev_idx_s;
            for (int k = 0; k < NUM_OPS; k++) begin
              operands_d[k*WIDTH +: WIDTH] = (prev_idx_s == IDXW'(k)) ?
                                             {WIDTH{1'b0}} : operands_q[k*WIDTH +: WIDTH];
            end
          end else if (del) begin
            op_index_d = op_index_q;
          end else
`endif
          if (data_valid) begin
            for (int k = 0; k < NUM_OPS; k++) begin
              operands_d[k*WIDTH +: WIDTH] = (op_index_q == IDXW'(k)) ?
                                             data_in : operands_q[k*WIDTH +: WIDTH];
            end
            if (op_index_q != LAST_IDX) begin
              op_index_d = op_index_q + IDX_ONE;
            end else begin
              state_d = FULL;
            end
          end else begin
            state_d = state_q;
          end
        end
        FULL: begin
          if (ops_ack) begin
            state_d    = COLLECT;
            op_index_d = IDX_ZERO;
`ifdef OPERAND_BANK_BACKSPACE_EN
          end else if (del) begin
            state_d    = COLLECT;
            op_index_d = LAST_IDX;
            operands_d[(NUM_OPS-1)*WIDTH +: WIDTH] = {WIDTH{1'b0}};
`endif
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d    = COLLECT;
          op_index_d = IDX_ZERO;
          operands_d = OPS_ZERO;
        end
      endcase
    end
    ops_ready_d = (state_d == FULL);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= COLLECT;
      op_index_q  <= IDX_ZERO;
      operands_q  <= OPS_ZERO;
      ops_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_index_q  <= op_index_d;
      operands_q  <= operands_d;
      ops_ready_q <= ops_ready_d;
    end
  end

  assign operands  = operands_q;
  assign op_index  = op_index_q;
  assign ops_ready = ops_ready_q;

endmodule

// File: tb/tb_operand_bank.sv
// Bench for operand_bank: directed vector table, hand sequences and a randomized run against a count-based model.
module tb_operand_bank;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  d2_din;
  logic        d2_dv, d2_clear, d2_ack, d2_ready;
  logic [15:0] d2_ops;
  logic [0:0]  d2_idx;
  logic [3:0]  d3_din;
  logic        d3_dv, d3_clear, d3_ack, d3_ready;
  logic [11:0] d3_ops;
  logic [1:0]  d3_idx;
`ifdef OPERAND_BANK_BACKSPACE_EN
  logic        d2_del, d3_del;
`endif

  operand_bank u_dut2 (
    .clk(clk), .rst(rst), .data_in(d2_din), .data_valid(d2_dv), .clear(d2_clear),
    .ops_ack(d2_ack),
`ifdef OPERAND_BANK_BACKSPACE_EN
    .del(d2_del),
`endif
    .operands(d2_ops), .op_index(d2_idx), .ops_ready(d2_ready)
  );

  operand_bank #(.WIDTH(4), .NUM_OPS(3)) u_dut3 (
    .clk(clk), .rst(rst), .data_in(d3_din), .data_valid(d3_dv), .clear(d3_clear),
    .ops_ack(d3_ack),
`ifdef OPERAND_BANK_BACKSPACE_EN
    .del(d3_del),
`endif
    .operands(d3_ops), .op_index(d3_idx), .ops_ready(d3_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a set is a count of captured operands; FULL means count == N.
  int m_n[2] = '{2, 3};
  int m_w[2] = '{8, 4};
  int m_ops[2][16];
  int m_cnt[2];

  task automatic model_step(input int u, input bit c, input bit a, input bit v, input int din);
    if (c) begin
      for (int k = 0; k < 16; k++) m_ops[u][k] = 0;
      m_cnt[u] = 0;
    end else if (m_cnt[u] == m_n[u]) begin
      if (a) m_cnt[u] = 0;
    end else if (v) begin
      m_ops[u][m_cnt[u]] = din;
      m_cnt[u]++;
    end
  endtask

  function automatic logic [63:0] m_flat(input int u);
    logic [63:0] f = 64'd0;
    for (int k = 0; k < m_n[u]; k++) f = f | (64'(m_ops[u][k]) << (k * m_w[u]));
    return f;
  endfunction

  function automatic logic [63:0] m_idx(input int u);
    return (m_cnt[u] == m_n[u]) ? 64'(m_n[u] - 1) : 64'(m_cnt[u]);
  endfunction

  task automatic step2(input bit c, input bit a, input bit v, input logic [7:0] din);
    @(negedge clk);
    d2_clear = c; d2_ack = a; d2_dv = v; d2_din = din;
    @(posedge clk);
    #1;
    d2_clear = 1'b0; d2_ack = 1'b0; d2_dv = 1'b0;
  endtask

  task automatic step3(input bit c, input bit a, input bit v, input logic [3:0] din);
    @(negedge clk);
    d3_clear = c; d3_ack = a; d3_dv = v; d3_din = din;
    @(posedge clk);
    #1;
    d3_clear = 1'b0; d3_ack = 1'b0; d3_dv = 1'b0;
  endtask

  typedef struct {
    bit         c;
    bit         a;
    bit         v;
    logic [7:0] din;
    logic [15:0] ops;
    logic [0:0] idx;
    bit         rdy;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 8'h12, 16'h0012, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'h34, 16'h3412, 1'b1, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'hFF, 16'h3412, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h3412, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 16'h3412, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h56, 16'h3456, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h78, 16'h7856, 1'b1, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'h99, 16'h0000, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'hAB, 16'h0000, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'hAB, 16'h00AB, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0};

    d2_din = 8'h00; d2_dv = 1'b0; d2_clear = 1'b0; d2_ack = 1'b0;
    d3_din = 4'h0;  d3_dv = 1'b0; d3_clear = 1'b0; d3_ack = 1'b0;
`ifdef OPERAND_BANK_BACKSPACE_EN
    d2_del = 1'b0; d3_del = 1'b0;
`endif

    // Reset state, including a clock edge during reset.
    d2_dv = 1'b1; d2_din = 8'h5A;
    #12;
    check("rst ops2", 64'(d2_ops), 64'd0);
    check("rst idx2", 64'(d2_idx), 64'd0);
    check("rst rdy2", 64'(d2_ready), 64'd0);
    check("rst ops3", 64'(d3_ops), 64'd0);
    check("rst idx3", 64'(d3_idx), 64'd0);
    d2_dv = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step2(tbl[i].c, tbl[i].a, tbl[i].v, tbl[i].din);
      check($sformatf("vec%0d ops", i), 64'(d2_ops), 64'(tbl[i].ops));
      check($sformatf("vec%0d idx", i), 64'(d2_idx), 64'(tbl[i].idx));
      check($sformatf("vec%0d rdy", i), 64'(d2_ready), 64'(tbl[i].rdy));
    end

    // Asynchronous reset between edges after one capture.
    step2(1'b0, 1'b0, 1'b1, 8'h42);
    check("pre-arst ops", 64'(d2_ops), 64'h0042);
    #2;
    rst = 1'b0;
    #1;
    check("arst ops", 64'(d2_ops), 64'd0);
    check("arst idx", 64'(d2_idx), 64'd0);
    check("arst rdy", 64'(d2_ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Three-operand, 4-bit instance: clear mid-collection, then a full set.
    step3(1'b0, 1'b0, 1'b1, 4'h1);
    step3(1'b0, 1'b0, 1'b1, 4'h2);
    check("n3 partial", 64'(d3_ops), 64'h021);
    step3(1'b1, 1'b0, 1'b0, 4'h0);
    step3(1'b0, 1'b0, 1'b1, 4'h3);
    check("n3 ops", 64'(d3_ops), 64'h003);
    check("n3 idx", 64'(d3_idx), 64'd1);
    check("n3 rdy", 64'(d3_ready), 64'd0);
    step3(1'b0, 1'b0, 1'b1, 4'h4);
    check("n3 rdy early", 64'(d3_ready), 64'd0);
    step3(1'b0, 1'b0, 1'b1, 4'h5);
    check("n3 full ops", 64'(d3_ops), 64'h543);
    check("n3 full idx", 64'(d3_idx), 64'd2);
    check("n3 full rdy", 64'(d3_ready), 64'd1);
    step3(1'b0, 1'b0, 1'b1, 4'h6);
    check("n3 hold ops", 64'(d3_ops), 64'h543);
    step3(1'b0, 1'b1, 1'b0, 4'h0);
    check("n3 ack ops", 64'(d3_ops), 64'h543);
    check("n3 ack idx", 64'(d3_idx), 64'd0);
    check("n3 ack rdy", 64'(d3_ready), 64'd0);

`ifdef OPERAND_BANK_BACKSPACE_EN
    step2(1'b1, 1'b0, 1'b0, 8'h00);
    step2(1'b0, 1'b0, 1'b1, 8'hAA);
    step2(1'b0, 1'b0, 1'b1, 8'hBB);
    check("bs full rdy", 64'(d2_ready), 64'd1);
    @(negedge clk);
    d2_del = 1'b1;
    @(posedge clk);
    #1;
    d2_del = 1'b0;
    check("bs del ops", 64'(d2_ops), 64'h00AA);
    check("bs del idx", 64'(d2_idx), 64'd1);
    check("bs del rdy", 64'(d2_ready), 64'd0);
    step2(1'b0, 1'b0, 1'b1, 8'hCC);
    check("bs refill ops", 64'(d2_ops), 64'hCCAA);
    check("bs refill rdy", 64'(d2_ready), 64'd1);
`endif

    // Randomized run on both instances, starting from a clear.
    @(negedge clk);
    d2_clear = 1'b1; d3_clear = 1'b1;
    model_step(0, 1'b1, 1'b0, 1'b0, 0);
    model_step(1, 1'b1, 1'b0, 1'b0, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      d2_clear = ($urandom_range(0, 15) == 0);
      d2_ack   = ($urandom_range(0, 3) == 0);
      d2_dv    = ($urandom_range(0, 1) == 1);
      d2_din   = 8'($urandom);
      d3_clear = ($urandom_range(0, 15) == 0);
      d3_ack   = ($urandom_range(0, 3) == 0);
      d3_dv    = ($urandom_range(0, 1) == 1);
      d3_din   = 4'($urandom);
      model_step(0, d2_clear, d2_ack, d2_dv, int'(d2_din));
      model_step(1, d3_clear, d3_ack, d3_dv, int'(d3_din));
      @(posedge clk);
      #1;
      check($sformatf("rnd%0d ops2", i), 64'(d2_ops), m_flat(0));
      check($sformatf("rnd%0d idx2", i), 64'(d2_idx), m_idx(0));
      check($sformatf("rnd%0d rdy2", i), 64'(d2_ready), 64'(m_cnt[0] == m_n[0]));
      check($sformatf("rnd%0d ops3", i), 64'(d3_ops), m_flat(1));
      check($sformatf("rnd%0d idx3", i), 64'(d3_idx), m_idx(1));
      check($sformatf("rnd%0d rdy3", i), 64'(d3_ready), 64'(m_cnt[1] == m_n[1]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
